quadrant_cmd_queue: RTL

- Downstream consumer of the PS/2 keyboard driver's one-hot `quadrant_confirm[15:0]` output.
- Turns each new confirm into a 4-bit quadrant index, drops malformed and duplicate (typematic-repeat / break-code) events, and queues accepted commands in a small FIFO.
- Hands commands to the processor/MMIO side over a valid/ready handshake.
- Provides a held one-hot LED image of the last accepted quadrant and sticky status flags.

---
 rtl/pisa_kbd_pkg.sv | 38 +++
 rtl/quad_cmd_fifo.sv | 65 ++++++
 rtl/quadrant_cmd_queue.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pisa_kbd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pisa_kbd_pkg
//  Description : Shared types, constants and helpers for the keyboard
//                quadrant command path.
//  Revision    : 1.0 - initial release
// ============================================================================
package pisa_kbd_pkg;

   localparam int NUM_QUADRANTS          = 16;
   localparam int DEFAULT_HOLDOFF_CYCLES = 25000000;

   typedef logic [3:0]               quadrant_idx_t;
   typedef logic [NUM_QUADRANTS-1:0] quadrant_onehot_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CHECK   = 2'd1,
      HOLDOFF = 2'd2
   } qcq_state_t;

   // Index of the highest set bit; only meaningful when the input is one-hot.
   function automatic quadrant_idx_t onehot_to_idx(input quadrant_onehot_t oh);
      quadrant_idx_t idx;
      idx = '0;
      for (int i = 0; i < NUM_QUADRANTS; i++) begin
         if (oh[i]) idx = quadrant_idx_t'(i);
      end
      return idx;
   endfunction

   // True when exactly one bit is set.
   function automatic logic is_onehot(input quadrant_onehot_t oh);
      return (oh != '0) && ((oh & (oh - quadrant_onehot_t'(1))) == '0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/quad_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : quad_cmd_fifo
//  Description : Synchronous first-word-fall-through FIFO of quadrant indices.
//                A push while full is accepted only if a pop frees a slot in
//                the same cycle; a pop while empty is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_cmd_fifo
   import pisa_kbd_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  quadrant_idx_t          push_data,
   input  logic                   pop,
   output quadrant_idx_t          head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   quadrant_idx_t   mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            do_push;
   logic            do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CNT_MAX);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   // Head is read straight from storage so it stays at the last value once drained.
   assign head    = mem[rd_ptr];

   // Storage and pointers; contents cleared on reset so the head reads zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/quadrant_cmd_queue.sv
`default_nettype none
// ============================================================================
//  Module      : quadrant_cmd_queue
//  Description : Converts one-hot keyboard quadrant confirms into queued
//                4-bit commands, rejecting malformed codes and repeats of the
//                same quadrant inside a holdoff window.
//  Revision    : 1.0 - initial release
// ============================================================================
module quadrant_cmd_queue
   import pisa_kbd_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int HOLDOFF_CYCLES = DEFAULT_HOLDOFF_CYCLES,
   parameter int HOLD_W         = 25
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_QUADRANTS-1:0] quadrant_confirm,
   input  logic                     cmd_ready,
   input  logic                     clr_status,
   output logic                     cmd_valid,
   output logic [3:0]               cmd_quadrant,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic [NUM_QUADRANTS-1:0] sel_led,
   output logic                     err_multi,
   output logic                     err_overflow
);

   localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLDOFF_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_ONE    = 1;

   qcq_state_t        state;
   qcq_state_t        state_nx;
   quadrant_onehot_t  confirm_q;
   logic              new_evt;
   quadrant_idx_t     evt_idx;
   logic              evt_ok;
   logic              evt_in_hold;
   quadrant_idx_t     last_idx;
   logic [HOLD_W-1:0] hold_cnt;
   logic              capture;
   logic              accept;
   logic              dup;
   logic              bad;
   logic              pop_req;
   logic              fifo_full;
   logic              fifo_empty;

   // A confirm level produces one event on its first non-zero cycle.
   assign new_evt = (quadrant_confirm != '0) && (quadrant_confirm != confirm_q);
   assign pop_req = cmd_valid && cmd_ready;
   assign cmd_valid = !fifo_empty;

   // Previous-cycle copy of the confirm bus for edge detection.
   always_ff @(posedge clk) begin
      if (rst) confirm_q <= '0;
      else     confirm_q <= quadrant_confirm;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // Next-state logic and one-cycle decision strobes.
   always_comb begin
      state_nx = state;
      capture  = 1'b0;
      accept   = 1'b0;
      dup      = 1'b0;
      bad      = 1'b0;
      case (state)
         IDLE: begin
            if (new_evt) begin
               capture  = 1'b1;
               state_nx = CHECK;
            end
         end
         CHECK: begin
            if (!evt_ok) begin
               bad      = 1'b1;
               state_nx = evt_in_hold ? HOLDOFF : IDLE;
            end else if (evt_in_hold && (evt_idx == last_idx)) begin
               dup      = 1'b1;
               state_nx = HOLDOFF;
            end else begin
               accept   = 1'b1;
               state_nx = HOLDOFF;
            end
         end
         HOLDOFF: begin
            if (new_evt) begin
               capture  = 1'b1;
               state_nx = CHECK;
            end else if (hold_cnt == '0) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Latch the event being judged; in_hold records whether a window was live.
   always_ff @(posedge clk) begin
      if (rst) begin
         evt_idx     <= '0;
         evt_ok      <= 1'b0;
         evt_in_hold <= 1'b0;
      end else if (capture) begin
         evt_idx     <= onehot_to_idx(quadrant_confirm);
         evt_ok      <= is_onehot(quadrant_confirm);
         evt_in_hold <= (state == HOLDOFF) && (hold_cnt != '0);
      end
   end

   // Holdoff window: restarted by accepts and by repeats so a held key never re-fires.
   always_ff @(posedge clk) begin
      if (rst)                  hold_cnt <= '0;
      else if (accept || dup)   hold_cnt <= HOLD_RELOAD;
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - HOLD_ONE;
   end

   // Last accepted quadrant and its LED image, updated even if the queue is full.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_idx <= '0;
         sel_led  <= '0;
      end else if (accept) begin
         last_idx <= evt_idx;
         sel_led  <= quadrant_onehot_t'(1) << evt_idx;
      end
   end

   // Sticky error flags; a new set condition beats a simultaneous clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_multi    <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         if (bad)             err_multi <= 1'b1;
         else if (clr_status) err_multi <= 1'b0;
         if (accept && fifo_full && !pop_req) err_overflow <= 1'b1;
         else if (clr_status)                 err_overflow <= 1'b0;
      end
   end

   quad_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (accept),
      .push_data (evt_idx),
      .pop       (pop_req),
      .head      (cmd_quadrant),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule
`default_nettype wire
